// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared command encodings and FSM states for the operand stack
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_TOS  = 3'd3,
        OP_POP2 = 3'd4,
        OP_REPL = 3'd5,
        OP_CLR  = 3'd6
    } stack_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RESP_A = 2'd1,
        S_RESP_B = 2'd2
    } stack_state_e;

endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - DEPTH x WIDTH operand storage, one sync write, two async reads
module stack_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/stack_unit_ctrl.sv
// rtl/stack_unit_ctrl.sv - operand stack controller with command/response handshake
// Optional high-water tracking of sp is enabled by defining STACK_HIGHWATER_EN.
module stack_unit_ctrl
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic [AW:0]      sp,
    output logic             empty,
    output logic             full,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic [AW:0]      hw_mark
);

    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0] SP_TWO  = (AW+1)'(2);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

    stack_state_e     state_q;
    logic [AW:0]      sp_q, sp_d;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [WIDTH-1:0] second_q;
    logic             pop2_q;
    logic             err_ovf_q;
    logic             err_unf_q;

    logic             accept;
    logic             is_empty, is_full, has_two;
    logic [AW:0]      sp_m1, sp_m2;
    logic [AW-1:0]    idx_top, idx_sec;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] rd_top, rd_sec;

    assign accept   = cmd_valid && cmd_ready_q;
    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_FULL);
    assign has_two  = (sp_q >= SP_TWO);
    assign sp_m1    = sp_q - SP_ONE;
    assign sp_m2    = sp_q - SP_TWO;
    assign idx_top  = sp_m1[AW-1:0];
    assign idx_sec  = sp_m2[AW-1:0];

    // Every guard against over/underflow lives here so sp never wraps.
    always_comb begin
        sp_d  = sp_q;
        we    = 1'b0;
        waddr = sp_q[AW-1:0];
        if (accept && !rst) begin
            case (cmd_op)
                OP_PUSH: if (!is_full) begin
                    we   = 1'b1;
                    sp_d = sp_q + SP_ONE;
                end
                OP_POP:  if (!is_empty) sp_d = sp_m1;
                OP_POP2: if (has_two)   sp_d = sp_m2;
                OP_REPL: if (!is_empty) begin
                    we    = 1'b1;
                    waddr = idx_top;
                end
                OP_CLR:  sp_d = '0;
                default: sp_d = sp_q;
            endcase
        end
    end

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk       (clk),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (cmd_data),
        .raddr_a_i (idx_top),
        .raddr_b_i (idx_sec),
        .rdata_a_o (rd_top),
        .rdata_b_o (rd_sec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sp_q        <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            second_q    <= '0;
            pop2_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            sp_q <= sp_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_PUSH: if (is_full) err_ovf_q <= 1'b1;
                            OP_POP, OP_TOS: begin
                                if (is_empty) begin
                                    err_unf_q <= 1'b1;
                                end else begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= rd_top;
                                    pop2_q      <= 1'b0;
                                    cmd_ready_q <= 1'b0;
                                    state_q     <= S_RESP_A;
                                end
                            end
                            OP_POP2: begin
                                if (!has_two) begin
                                    err_unf_q <= 1'b1;
                                end else begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= rd_top;
                                    second_q    <= rd_sec;
                                    pop2_q      <= 1'b1;
                                    cmd_ready_q <= 1'b0;
                                    state_q     <= S_RESP_A;
                                end
                            end
                            OP_REPL: if (is_empty) err_unf_q <= 1'b1;
                            OP_CLR: begin
                                err_ovf_q <= 1'b0;
                                err_unf_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RESP_A: begin
                    if (pop2_q) begin
                        rsp_data_q <= second_q;
                        state_q    <= S_RESP_B;
                    end else begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STACK_HIGHWATER_EN
    logic [AW:0] hw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hw_q <= '0;
        end else if (sp_d > hw_q) begin
            hw_q <= sp_d;
        end
    end

    assign hw_mark = hw_q;
`else
    assign hw_mark = '0;
`endif

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign sp            = sp_q;
    assign empty         = is_empty;
    assign full          = is_full;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_stack_unit_ctrl.sv
// tb/tb_stack_unit_ctrl.sv - directed self-checking bench for stack_unit_ctrl
module tb_stack_unit_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic [AW:0]      sp;
    logic             empty, full;
    logic             err_overflow, err_underflow;
    logic [AW:0]      hw_mark;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, TOS = 3'd3,
                           POP2 = 3'd4, REPL = 3'd5, CLR = 3'd6;

`ifdef STACK_HIGHWATER_EN
    localparam bit HW_ON = 1'b1;
`else
    localparam bit HW_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    stack_unit_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .sp            (sp),
        .empty         (empty),
        .full          (full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .hw_mark       (hw_mark)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [WIDTH-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = NOP;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_sp", sp, 5'd0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_errs", {err_overflow, err_underflow}, 2'b00);
        chk("rst_hw", hw_mark, 5'd0);
        rst = 1'b0;

        cmd(PUSH, 8'h11);
        cmd(PUSH, 8'h22);
        cmd(PUSH, 8'h33);
        chk("push3_sp", sp, 5'd3);

        cmd(POP2, 8'h00);
        chk("pop2_a_valid", rsp_valid, 1'b1);
        chk("pop2_a_data", rsp_data, 8'h33);
        chk("pop2_a_ready", cmd_ready, 1'b0);
        chk("pop2_sp", sp, 5'd1);
        tick();
        chk("pop2_b_valid", rsp_valid, 1'b1);
        chk("pop2_b_data", rsp_data, 8'h22);
        chk("pop2_b_ready", cmd_ready, 1'b0);
        tick();
        chk("pop2_end_valid", rsp_valid, 1'b0);
        chk("pop2_end_ready", cmd_ready, 1'b1);
        chk("pop2_hold_data", rsp_data, 8'h22);

        cmd(POP2, 8'h00);
        chk("pop2_unf_err", err_underflow, 1'b1);
        chk("pop2_unf_sp", sp, 5'd1);
        chk("pop2_unf_valid", rsp_valid, 1'b0);
        chk("pop2_unf_ready", cmd_ready, 1'b1);
        cmd(CLR, 8'h00);
        chk("clr_sp", sp, 5'd0);
        chk("clr_err_unf", err_underflow, 1'b0);

        cmd(POP, 8'h00);
        chk("pop_empty_err", err_underflow, 1'b1);
        chk("pop_empty_valid", rsp_valid, 1'b0);
        cmd(CLR, 8'h00);

        cmd(PUSH, 8'h5A);
        cmd(TOS, 8'h00);
        chk("tos_valid", rsp_valid, 1'b1);
        chk("tos_data", rsp_data, 8'h5A);
        chk("tos_sp", sp, 5'd1);
        tick();
        chk("tos_end_valid", rsp_valid, 1'b0);
        cmd(REPL, 8'hA5);
        chk("repl_sp", sp, 5'd1);
        cmd(TOS, 8'h00);
        chk("repl_tos_data", rsp_data, 8'hA5);
        tick();
        cmd(7, 8'hFF);
        chk("op7_sp", sp, 5'd1);
        chk("op7_valid", rsp_valid, 1'b0);

        cmd(CLR, 8'h00);
        for (int i = 0; i < 5; i++) cmd(PUSH, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) begin
            cmd(POP, 8'h00);
            chk("hw_pop_data", rsp_data, 8'(8'h44 - i));
            tick();
        end
        cmd(PUSH, 8'h77);
        chk("hw_sp", sp, 5'd3);
        chk("hw_mark5", hw_mark, HW_ON ? 5'd5 : 5'd0);

        cmd(CLR, 8'h00);
        for (int i = 0; i < DEPTH; i++) cmd(PUSH, 8'(i + 1));
        chk("full_flag", full, 1'b1);
        chk("full_sp", sp, 5'd16);
        chk("full_no_ovf", err_overflow, 1'b0);
        cmd(PUSH, 8'hEE);
        chk("ovf_err", err_overflow, 1'b1);
        chk("ovf_sp", sp, 5'd16);
        cmd(TOS, 8'h00);
        chk("ovf_top", rsp_data, 8'h10);
        tick();
        chk("hw_mark16", hw_mark, HW_ON ? 5'd16 : 5'd0);
        cmd(CLR, 8'h00);
        chk("ovf_clr_sp", sp, 5'd0);
        chk("ovf_clr_err", err_overflow, 1'b0);
        chk("ovf_clr_full", full, 1'b0);
        chk("clr_keeps_hw", hw_mark, HW_ON ? 5'd16 : 5'd0);

        cmd(PUSH, 8'h01);
        cmd(PUSH, 8'h02);
        cmd(POP2, 8'h00);
        chk("abort_in_resp_a", rsp_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", rsp_valid, 1'b0);
        chk("abort_sp", sp, 5'd0);
        chk("abort_ready", cmd_ready, 1'b1);
        chk("abort_hw", hw_mark, 5'd0);
        tick();
        chk("abort_stay_idle", rsp_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
